// File: rtl/ip4_pkg.sv
// IPv4 constants, config-register layout and FSM states shared by the IPv4 encap and parser blocks.
package ip4_pkg;
    localparam int SA_IP4_SIZE   = 4;
    localparam int DA_IP4_SIZE   = 4;
    localparam int IP4_HDR_BYTES = 20;

    localparam logic [7:0]  IP4_VER_IHL  = 8'h45;
    localparam logic [15:0] IP4_FLAGS_DF = 16'h4000;

    // ip4_config_regs = {dst_ip, src_ip, proto, ttl}
    localparam int CFG_TTL_LSB   = 0;
    localparam int CFG_PROTO_LSB = 8;
    localparam int CFG_SRC_LSB   = 16;
    localparam int CFG_DST_LSB   = 48;
    localparam int CFG_WIDTH     = 80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_BODY,
        ST_TAIL
    } encap_state_e;

    // Place a big-endian field onto little-lane AXIS bytes (network byte 0 in [7:0]).
    function automatic logic [15:0] net16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] net32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction
endpackage

// File: rtl/ip4_csum_calc.sv
// Combinational IPv4 header checksum: one's-complement sum of ten 16-bit words, folded and inverted.
// Fed a header whose checksum field is filled in, a valid header yields 16'h0000.
module ip4_csum_calc (
    input  logic [159:0] hdr_words,   // word 0 in [159:144]
    output logic [15:0]  csum
);
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // NOTE: every always_comb output gets a value before any branch so no latch can be inferred.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + {4'd0, hdr_words[i*16 +: 16]};
        end
        // Two folds suffice: the first can carry out only when its low half is tiny.
        fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        csum  = ~fold2;
    end
endmodule

// File: rtl/ip4_encap.sv
// Prepends a 20-byte IPv4 header (no options) to a 64-bit payload AXI stream.
module ip4_encap
    import ip4_pkg::*;
#(
    parameter int  AXIS_BUS_WIDTH    = 64,
    parameter int  AXIS_ID_WIDTH     = 4,
    parameter int  AXIS_DEST_WIDTH   = 0,
    parameter int  MAX_PACKET_LENGTH = 1522,
    localparam int EFF_ID_WIDTH      = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
    localparam int EFF_DEST_WIDTH    = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
    localparam int LEN_W             = $clog2(MAX_PACKET_LENGTH + 1)
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]              axis_in_tdata,
    input  logic [LEN_W-1:0]                       axis_in_tuser,
    input  logic [EFF_ID_WIDTH-1:0]                axis_in_tid,
    input  logic [EFF_DEST_WIDTH-1:0]              axis_in_tdest,
    input  logic [7:0]                             axis_in_tkeep,
    input  logic                                   axis_in_tlast,
    input  logic                                   axis_in_tvalid,
    output logic                                   axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]              axis_out_tdata,
    output logic [LEN_W-1:0]                       axis_out_tuser,
    output logic [EFF_ID_WIDTH-1:0]                axis_out_tid,
    output logic [EFF_DEST_WIDTH-1:0]              axis_out_tdest,
    output logic [7:0]                             axis_out_tkeep,
    output logic                                   axis_out_tlast,
    output logic                                   axis_out_tvalid,
    input  logic                                   axis_out_tready,
    output logic [EFF_ID_WIDTH+EFF_DEST_WIDTH-1:0] ip4_config_sel,
    input  logic [CFG_WIDTH-1:0]                   ip4_config_regs
);
    if (AXIS_BUS_WIDTH != 64) begin : g_width_check
        $error("ip4_encap supports only AXIS_BUS_WIDTH = 64");
    end

    encap_state_e              state_q, state_d;
    logic [CFG_WIDTH-1:0]      cfg_q;
    logic [EFF_ID_WIDTH-1:0]   tid_q;
    logic [EFF_DEST_WIDTH-1:0] tdest_q;
    logic [LEN_W-1:0]          tot_len_q;
    logic [15:0]               ident_q;
    logic [15:0]               csum_q, csum_d;
    logic [31:0]               saved_q;
    logic [3:0]                saved_keep_q;

    logic                      out_load, in_ready, in_fire, emit, beat_last;
    logic [63:0]               beat_data;
    logic [7:0]                beat_keep;

    logic [7:0]                ttl, proto;
    logic [SA_IP4_SIZE*8-1:0]  src_ip;
    logic [DA_IP4_SIZE*8-1:0]  dst_ip;
    logic [15:0]               tot_len16;

    assign ttl       = cfg_q[CFG_TTL_LSB +: 8];
    assign proto     = cfg_q[CFG_PROTO_LSB +: 8];
    assign src_ip    = cfg_q[CFG_SRC_LSB +: SA_IP4_SIZE*8];
    assign dst_ip    = cfg_q[CFG_DST_LSB +: DA_IP4_SIZE*8];
    assign tot_len16 = 16'(tot_len_q);

    assign ip4_config_sel = {axis_in_tid, axis_in_tdest};
    assign axis_in_tready = in_ready;
    assign in_fire        = axis_in_tvalid && in_ready;

    ip4_csum_calc u_csum (
        .hdr_words ({IP4_VER_IHL, 8'h00, tot_len16, ident_q, IP4_FLAGS_DF,
                     ttl, proto, 16'h0000, src_ip, dst_ip}),
        .csum      (csum_d)
    );

    always_comb begin
        state_d   = state_q;
        out_load  = !axis_out_tvalid || axis_out_tready;
        in_ready  = 1'b0;
        emit      = 1'b0;
        beat_data = '0;
        beat_keep = 8'hFF;
        beat_last = 1'b0;
        case (state_q)
            ST_IDLE: if (axis_in_tvalid) state_d = ST_CALC;
            ST_CALC: state_d = ST_HDR0;
            ST_HDR0: begin
                emit      = 1'b1;
                beat_data = {net16(IP4_FLAGS_DF), net16(ident_q), net16(tot_len16),
                             net16({IP4_VER_IHL, 8'h00})};
                if (out_load) state_d = ST_HDR1;
            end
            ST_HDR1: begin
                emit      = 1'b1;
                beat_data = {net32(src_ip), net16(csum_q), net16({ttl, proto})};
                if (out_load) state_d = ST_HDR2;
            end
            ST_HDR2, ST_BODY: begin
                // Output lags input by four bytes: low half is dst_ip or the previous beat's upper half.
                in_ready  = out_load;
                emit      = axis_in_tvalid;
                beat_data = {axis_in_tdata[31:0], (state_q == ST_HDR2) ? net32(dst_ip) : saved_q};
                if (axis_in_tlast && !axis_in_tkeep[4]) begin
                    beat_keep = {axis_in_tkeep[3:0], 4'hF};
                    beat_last = 1'b1;
                end
                if (in_fire) begin
                    if (!axis_in_tlast)       state_d = ST_BODY;
                    else if (axis_in_tkeep[4]) state_d = ST_TAIL;
                    else                       state_d = ST_IDLE;
                end
            end
            ST_TAIL: begin
                emit      = 1'b1;
                beat_data = {32'h0, saved_q};
                beat_keep = {4'h0, saved_keep_q};
                beat_last = 1'b1;
                if (out_load) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_q           <= '0;
            tid_q           <= '0;
            tdest_q         <= '0;
            tot_len_q       <= '0;
            ident_q         <= '0;
            csum_q          <= '0;
            saved_q         <= '0;
            saved_keep_q    <= '0;
            axis_out_tdata  <= '0;
            axis_out_tuser  <= '0;
            axis_out_tid    <= '0;
            axis_out_tdest  <= '0;
            axis_out_tkeep  <= '0;
            axis_out_tlast  <= 1'b0;
            axis_out_tvalid <= 1'b0;
        end else begin
            // Snapshot config at packet start so later register writes cannot corrupt this header.
            if (state_q == ST_IDLE && axis_in_tvalid) begin
                cfg_q     <= ip4_config_regs;
                tid_q     <= axis_in_tid;
                tdest_q   <= axis_in_tdest;
                tot_len_q <= axis_in_tuser + LEN_W'(IP4_HDR_BYTES);
            end
            if (state_q == ST_CALC) csum_q <= csum_d;
            if (in_fire) begin
                saved_q      <= axis_in_tdata[63:32];
                saved_keep_q <= axis_in_tkeep[7:4];
            end
            if (out_load) begin
                axis_out_tvalid <= emit;
                if (emit) begin
                    axis_out_tdata <= beat_data;
                    axis_out_tkeep <= beat_keep;
                    axis_out_tlast <= beat_last;
                    axis_out_tuser <= tot_len_q;
                    axis_out_tid   <= tid_q;
                    axis_out_tdest <= tdest_q;
                    if (beat_last) ident_q <= ident_q + 16'd1;
                end
            end
        end
    end
endmodule
